// File: rtl/count_pkg.sv
// -----------------------------------------------------------------------------
// count_pkg
//   Shared definitions for the bit-count unit: operand width, counter width,
//   operation encodings and FSM state encoding.
// -----------------------------------------------------------------------------
package count_pkg;

  localparam int XLEN  = 32;
  // Enough bits to hold a count of 0..XLEN inclusive.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    OP_CLZ  = 2'b00,
    OP_CTZ  = 2'b01,
    OP_CPOP = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/count_unit.sv
// -----------------------------------------------------------------------------
// count_unit
//   Iterative bit-count unit: count leading zeros, count trailing zeros,
//   population count, or pass-through of a 32-bit operand. One bit is examined
//   per clock, so latency depends on the operand.
//
// Ports
//   clk    in   single clock, all state changes on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   request; only accepted when not busy (IDLE or DONE)
//   op     in   00 clz, 01 ctz, 10 cpop, 11 pass-through
//   a      in   operand, captured together with an accepted start
//   busy   out  high while an operation is running
//   done   out  one-cycle pulse; r is valid in that cycle
//   r      out  registered result, held until the next accepted start
// -----------------------------------------------------------------------------
module count_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] r
);

  import count_pkg::*;

  // Result reported by clz/ctz when the operand has no set bit at all.
  localparam logic [XLEN-1:0] ALL_ZERO_RESULT = XLEN'(XLEN);

  state_e           state;
  op_e              opr;
  logic [XLEN-1:0]  sr;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here, including the outputs, is assigned with <= so
  // that all of them update together from the values seen before the edge;
  // mixing in blocking assignments would make the shift and the test of the
  // same sr bit order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is sampled on the clock edge only, and clears the
      // datapath too, so an abandoned operation leaves no stale result behind.
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      r     <= '0;
      sr    <= '0;
      cnt   <= '0;
      opr   <= OP_CLZ;
    end else begin
      // done is a pulse: only the RUN-to-DONE transition raises it.
      done <= 1'b0;

      unique case (state)
        // DONE behaves like IDLE for accepting a new request, which is what
        // allows back-to-back operations without an idle gap.
        IDLE, DONE: begin
          if (start) begin
            sr    <= a;
            cnt   <= '0;
            opr   <= op_e'(op);
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        RUN: begin
          unique case (opr)
            OP_CLZ: begin
              if (sr == '0) begin
                r     <= ALL_ZERO_RESULT;
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (sr[XLEN-1]) begin
                r     <= XLEN'(cnt);
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                sr  <= sr << 1;
                cnt <= cnt + CNT_W'(1);
              end
            end

            OP_CTZ: begin
              if (sr == '0) begin
                r     <= ALL_ZERO_RESULT;
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (sr[0]) begin
                r     <= XLEN'(cnt);
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                sr  <= sr >> 1;
                cnt <= cnt + CNT_W'(1);
              end
            end

            OP_CPOP: begin
              // Stops as soon as the remaining bits are all zero, so the
              // latency tracks the highest set bit rather than the width.
              if (sr == '0) begin
                r     <= XLEN'(cnt);
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(sr[0]);
                sr  <= sr >> 1;
              end
            end

            OP_PASS: begin
              r     <= sr;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end

            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_unit.sv
// -----------------------------------------------------------------------------
// tb_count_unit
//   Self-checking bench for count_unit. Each request pushes its expected result
//   and latency onto a scoreboard queue; the entry is popped and compared when
//   the DUT raises done.
// -----------------------------------------------------------------------------
module tb_count_unit;

  import count_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic        busy;
  logic        done;
  logic [31:0] r;

  typedef struct {
    logic [31:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  count_unit #(.XLEN(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .busy (busy),
    .done (done),
    .r    (r)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model (used for the randomised section only)
  // ---------------------------------------------------------------------------
  function automatic int msb_index(input logic [31:0] v);
    int idx = -1;
    for (int i = 0; i < 32; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  function automatic int lsb_index(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 32;
  endfunction

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] v);
    exp_t e;
    int   ones = 0;
    for (int i = 0; i < 32; i++) ones += int'(v[i]);
    if (o == OP_PASS) begin
      e.r = v; e.lat = 2;
    end else if (v == 32'h0) begin
      e.r = (o == OP_CPOP) ? 32'd0 : 32'd32; e.lat = 2;
    end else if (o == OP_CLZ) begin
      e.r = 32'(31 - msb_index(v)); e.lat = int'(e.r) + 2;
    end else if (o == OP_CTZ) begin
      e.r = 32'(lsb_index(v)); e.lat = int'(e.r) + 2;
    end else begin
      e.r = 32'(ones); e.lat = msb_index(v) + 3;
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // Presents one request for a single edge, then scrambles op/a so that any
  // late sampling of the operand shows up as a wrong result.
  task automatic issue(input logic [1:0] o, input logic [31:0] v,
                       input logic [31:0] er, input int el);
    exp_t e;
    e.r = er; e.lat = el;
    sb.push_back(e);
    start = 1'b1; op = o; a = v;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom;
  endtask

  // Called right after issue(): the start edge counts as latency cycle 1.
  // inject_at > 0 raises a conflicting start for three cycles mid-run.
  task automatic wait_done(input string name, input int inject_at,
                           output int busy_cycles);
    exp_t e;
    int   cyc = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) busy_cycles++;
      if (inject_at > 0 && cyc == inject_at) begin
        start = 1'b1; op = OP_CTZ; a = 32'h2;
      end
      if (inject_at > 0 && cyc == inject_at + 3) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: no expectation queued", name);
    end else begin
      e = sb.pop_front();
      if (done !== 1'b1) begin
        n_fail++;
        $display("FAIL %s timeout: done not seen within %0d cycles, expected latency %0d",
                 name, cyc, e.lat);
      end else begin
        if (cyc !== e.lat) begin
          n_fail++;
          $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
        end
        n_checks++;
        if (r !== e.r) begin
          n_fail++;
          $display("FAIL %s result: got %h expected %h", name, r, e.r);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // rst wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; op = OP_PASS; a = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, r} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b r=%h expected 0 0 0", busy, done, r);
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, r} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b r=%h expected 0 0 0", busy, done, r);
    end
  endtask

  task automatic test_clz();
    int bc;
    issue(OP_CLZ, 32'h0000_1000, 32'd19, 21);
    wait_done("clz_1000", 0, bc);
    n_checks++;
    if (bc !== 20) begin
      n_fail++;
      $display("FAIL clz_1000 busy_cycles: got %0d expected 20", bc);
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    issue(OP_CTZ, 32'h0000_0000, 32'd32, 2);
    wait_done("ctz_zero", 0, bc);
    // Issued in the DONE cycle of the previous request.
    issue(OP_CLZ, 32'h8000_0000, 32'd0, 2);
    wait_done("clz_msb_b2b", 0, bc);
  endtask

  task automatic test_cpop();
    int bc;
    issue(OP_CPOP, 32'hFFFF_FFFF, 32'd32, 34);
    wait_done("cpop_ffffffff", 0, bc);
    @(posedge clk); #1;
    issue(OP_CPOP, 32'h0000_00A5, 32'd4, 10);
    wait_done("cpop_a5", 0, bc);
  endtask

  task automatic test_ignore_start();
    int bc;
    @(posedge clk); #1;
    issue(OP_CLZ, 32'h0000_0001, 32'd31, 33);
    wait_done("clz_1_ignore_start", 6, bc);
  endtask

  task automatic test_reset_mid_run();
    int bc;
    bit seen = 1'b0;
    @(posedge clk); #1;
    issue(OP_CLZ, 32'h0000_0100, 32'd23, 25);
    repeat (4) @(posedge clk);   // now in the 5th RUN cycle
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    n_checks++;
    if ({busy, done, r} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b r=%h expected 0 0 0", busy, done, r);
    end
    bc = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
      if (busy === 1'b1) bc++;
    end
    n_checks++;
    if (seen || bc != 0) begin
      n_fail++;
      $display("FAIL reset_mid_run_quiet: done_seen=%b busy_cycles=%0d expected 0 0", seen, bc);
    end
  endtask

  task automatic test_pass_hold();
    int bc;
    int bad = 0;
    issue(OP_PASS, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2);
    wait_done("pass_deadbeef", 0, bc);
    repeat (10) begin
      @(posedge clk); #1;
      if (r !== 32'hDEAD_BEEF || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pass_hold: %0d of 10 idle cycles had r=%h done=%b busy=%b, expected r=deadbeef done=0 busy=0",
               bad, r, done, busy);
    end
  endtask

  task automatic test_random_back_to_back();
    int          bc;
    logic [1:0]  o;
    logic [31:0] v;
    exp_t        e;
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom);
      v = $urandom >> $urandom_range(0, 31);
      if (i % 5 == 0) v = 32'h0;
      e = model(o, v);
      issue(o, v, e.r, e.lat);
      wait_done($sformatf("random_%0d_op%0d_%h", i, o, v), 0, bc);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'h0;
    test_reset();
    test_clz();
    test_back_to_back();
    test_cpop();
    test_ignore_start();
    test_reset_mid_run();
    test_pass_hold();
    test_random_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
